axi_lite_read_arbiter: RTL and testbench
========================================

// Module: axi_lite_read_arbiter
// PURPOSE
//  Shares one AXI-Lite read slave (ROM/RAM slave interface) between two AXI-Lite read masters:
//  M0 = instruction-fetch bus matrix, M1 = load/store data path.
//  Sits between the master-side AXI-Lite interfaces and the single slave-side AXI-Lite interface.
//  Allows only one read in flight: the grant is held from AR accept until the R handshake.
// PARAMETERS
//  ADDR_W    64  address width (matches `AddrBus)
//  DATA_W    64  data width (matches `DataBus)
//  ARB_MODE  0   0 = round-robin between M0/M1; 1 = fixed priority, M0 always wins a tie
// PORTS
//  ACLK        in   1       clock, rising edge
//  ARESETn     in   1       asynchronous active-low reset
//  M0_ARVALID  in   1       M0 read address valid
//  M0_ARADDR   in   ADDR_W  M0 read address
//  M0_ARPROT   in   3       M0 protection bits
//  M0_ARREADY  out  1       M0 address accepted
//  M0_RVALID   out  1       M0 read data valid
//  M0_RDATA    out  DATA_W  M0 read data
//  M0_RRESP    out  3       M0 read response
//  M0_RREADY   in   1       M0 ready for data
//  M1_*        same set as M0, for master 1
//  S_ARVALID   out  1       slave address valid
//  S_ARADDR    out  ADDR_W  slave address (registered)
//  S_ARPROT    out  3       slave protection bits (registered)
//  S_ARREADY   in   1       slave accepted address
//  S_RVALID    in   1       slave data valid
//  S_RDATA     in   DATA_W  slave data
//  S_RRESP     in   3       slave response
//  S_RREADY    out  1       arbiter ready for slave data
// BEHAVIOUR
//  Reset values: state IDLE, grant = none, rr_ptr = 0 (M0 favoured), addr/prot registers = 0.
//   All VALID/READY outputs = 0; all data/resp outputs = 0. Reset takes effect immediately, at any state.
//  FSM has three states:
//   IDLE -> ADDR: taken when any Mx_ARVALID = 1.
//    The winner's Mx_ARREADY = 1 combinationally in that same cycle.
//    The winner's ARADDR/ARPROT are latched into the addr/prot registers, and grant is registered.
//   ADDR: S_ARVALID = 1, with S_ARADDR/S_ARPROT driven from the registers and held stable.
//    On S_ARVALID & S_ARREADY -> DATA.
//   DATA: S_RVALID, S_RDATA and S_RRESP are routed to the granted master only.
//    S_RREADY = granted Mx_RREADY.
//    On the S_RVALID & Mx_RREADY handshake -> IDLE, grant cleared, and rr_ptr = the other master.
//  Arbitration (IDLE only):
//   Single requester: it wins.
//   Both requesting, ARB_MODE=0: rr_ptr selects the winner.
//   Both requesting, ARB_MODE=1: M0 wins.
//   A single-requester win also advances rr_ptr past the winner.
//  The non-granted master always sees ARREADY = 0, RVALID = 0 and RDATA/RRESP = 0.
//   Its ARVALID stays pending and is never dropped.
//  Latency: from the M ARVALID cycle to the earliest S_ARVALID is 1 cycle.
//   From the S R handshake to the next M ARREADY is 1 cycle (back in IDLE).
//   Best-case throughput is one read every 3 cycles.
//  Mx_ARREADY is asserted only in IDLE. A new request arriving in ADDR/DATA waits.
//  The slave holding ARREADY low, or a master holding RREADY low, stalls indefinitely. No timeout.
//  RRESP is passed through unmodified. The arbiter never generates error responses.
//  Mx_ARVALID falling while not yet accepted is an AXI violation and is not handled.
// STRUCTURE
//  Shared defines file (defines.v): `AddrBus/`DataBus, state encodings ARB_IDLE/ARB_ADDR/ARB_DATA,
//   and RESP constants (OKAY = 3'b000, SLVERR = 3'b010).
//  One sub-module, read_arb_pick: combinational 2-way winner select from valids, rr_ptr and ARB_MODE.
//   The pointer register stays in the parent.
//  Parent contains the FSM, the address/prot capture registers and the R-channel routing muxes.
// TESTING
//  1. M0_ARVALID with addr 0x8000_0000, slave answers 0x0000_0013 OKAY.
//     Required: M0_ARREADY in the same cycle; S_ARADDR = 0x8000_0000 one cycle later.
//     Required: M0_RDATA = 0x13 and M1_RVALID stays 0.
//  2. ARB_MODE=0, both masters hold ARVALID continuously from reset.
//     Required: grants go M0, M1, M0, M1, each getting its own address and data.
//  3. ARB_MODE=1, same stimulus.
//     Required: M0 is granted every time and M1_ARREADY never rises while M0 requests.
//  4. Stall: S_ARREADY low for 3 cycles, then M0_RREADY low for 2 cycles after S_RVALID.
//     Required: S_ARVALID/S_ARADDR stable throughout; M0_RVALID/RDATA stable until the handshake.
//     Required: exactly one transfer occurs.
//  5. M1_ARVALID raised while M0 is in DATA.
//     Required: M1_ARREADY stays 0 until the cycle after M0's R handshake, then M1 is served.
//  6. ARESETn pulsed low during ADDR.
//     Required: all outputs read 0 immediately.
//     Required: after release, a new M1 request (addr 0x8000_0010) completes normally.

Source files
------------

// File: rtl/axi_lite_read_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite read arbiter.
//   - bus widths used as parameter defaults
//   - FSM state encoding (also exported on the debug port)
//   - AXI response codes and arbitration mode selectors
package axi_lite_read_arbiter_pkg;

  localparam int ADDR_BUS = 64;
  localparam int DATA_BUS = 64;

  localparam int ARB_RR    = 0;  // round-robin between M0/M1
  localparam int ARB_FIXED = 1;  // M0 always wins a tie

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,  // waiting for a master request
    ARB_ADDR = 2'd1,  // presenting the captured address to the slave
    ARB_DATA = 2'd2   // waiting for the slave R beat to reach the granted master
  } arb_state_e;

endpackage

// File: rtl/axi_lite_read_arbiter_pick.sv
// Combinational 2-way winner select.
// Ports:
//   req0, req1 : ARVALID of master 0 / master 1
//   rr_ptr     : round-robin pointer (0 = M0 favoured, 1 = M1 favoured)
//   any        : at least one master is requesting
//   win1       : 1 when master 1 wins, 0 when master 0 wins (meaningful only with any)
// The pointer register itself lives in the parent.
module axi_lite_read_arbiter_pick
  import axi_lite_read_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic any,
  output logic win1
);

  always_comb begin
    any  = req0 | req1;
    win1 = 1'b0;
    if (req0 && req1) begin
      // Contention: fixed mode always favours M0, round-robin follows the pointer.
      win1 = (ARB_MODE == ARB_FIXED) ? 1'b0 : rr_ptr;
    end else begin
      win1 = req1;
    end
  end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Shares one AXI-Lite read slave between two AXI-Lite read masters
// (M0 = instruction fetch, M1 = load/store). Only one read is in flight:
// the grant is held from AR acceptance until the R handshake.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both 1; VALID is never withdrawn before that
// edge and its payload is held stable while VALID is high.
//
// Ports:
//   ACLK, ARESETn        clock (rising edge), asynchronous active-low reset
//   M0_* / M1_*          master-side AR and R channels
//   S_*                  slave-side AR and R channels (S_ARADDR/S_ARPROT registered)
//   dbg_state            current FSM state, for observation only
module axi_lite_read_arbiter
  import axi_lite_read_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_BUS,
  parameter int DATA_W   = DATA_BUS,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0
  input  logic              M0_ARVALID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [2:0]        M0_ARPROT,
  output logic              M0_ARREADY,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic [2:0]        M0_RRESP,
  input  logic              M0_RREADY,
  // master 1
  input  logic              M1_ARVALID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [2:0]        M1_ARPROT,
  output logic              M1_ARREADY,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [2:0]        M1_RRESP,
  input  logic              M1_RREADY,
  // slave
  output logic              S_ARVALID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [2:0]        S_ARPROT,
  input  logic              S_ARREADY,
  input  logic              S_RVALID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [2:0]        S_RRESP,
  output logic              S_RREADY,
  // observation
  output arb_state_e        dbg_state
);

  arb_state_e        state_q, state_d;
  logic              grant_q;   // 1 = M1 owns the slave; only meaningful outside IDLE
  logic              rr_ptr_q;  // 0 = M0 favoured on the next tie
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        prot_q;

  logic any_req, win1;
  logic accept;      // AR accepted from a master this cycle
  logic gnt_rready;
  logic r_done;      // R handshake between slave and granted master

  axi_lite_read_arbiter_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .req0   (M0_ARVALID),
    .req1   (M1_ARVALID),
    .rr_ptr (rr_ptr_q),
    .any    (any_req),
    .win1   (win1)
  );

  assign gnt_rready = grant_q ? M1_RREADY : M0_RREADY;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    r_done  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (S_ARREADY) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        if (S_RVALID && gnt_rready) begin
          r_done  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Grant, pointer and AR capture registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      addr_q   <= '0;
      prot_q   <= '0;
    end else begin
      if (accept) begin
        grant_q  <= win1;
        addr_q   <= win1 ? M1_ARADDR : M0_ARADDR;
        prot_q   <= win1 ? M1_ARPROT : M0_ARPROT;
        // Pointer moves past the winner at acceptance; the value it would
        // take at the R handshake is the same, so contended and single
        // wins behave identically.
        rr_ptr_q <= ~win1;
      end
      if (r_done) begin
        grant_q  <= 1'b0;
        rr_ptr_q <= ~grant_q;
      end
    end
  end

  // ARREADY is combinational from the request; gating with the reset pin
  // keeps it low while reset is asserted even if a master is requesting.
  assign M0_ARREADY = ARESETn & accept & ~win1;
  assign M1_ARREADY = ARESETn & accept &  win1;

  assign S_ARVALID = (state_q == ARB_ADDR);
  assign S_ARADDR  = addr_q;
  assign S_ARPROT  = prot_q;
  assign S_RREADY  = (state_q == ARB_DATA) & gnt_rready;

  // R routing: only the granted master sees the slave; the other reads zeros.
  logic route0, route1;
  assign route0 = (state_q == ARB_DATA) & ~grant_q;
  assign route1 = (state_q == ARB_DATA) &  grant_q;

  assign M0_RVALID = route0 & S_RVALID;
  assign M0_RDATA  = route0 ? S_RDATA : '0;
  assign M0_RRESP  = route0 ? S_RRESP : 3'b000;
  assign M1_RVALID = route1 & S_RVALID;
  assign M1_RDATA  = route1 ? S_RDATA : '0;
  assign M1_RRESP  = route1 ? S_RRESP : 3'b000;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Bench for axi_lite_read_arbiter: instance 0 runs round-robin, instance 1
// fixed priority. A small reactive slave answers each accepted address one
// cycle later with data = addr - 0x7FFF_FFED and resp = SLVERR when addr[4]=1.
module tb_axi_lite_read_arbiter;
  import axi_lite_read_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic aclk;
  logic aresetn [2];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic        m0_arvalid [2];
  logic [63:0] m0_araddr  [2];
  logic [2:0]  m0_arprot  [2];
  logic        m0_arready [2];
  logic        m0_rvalid  [2];
  logic [63:0] m0_rdata   [2];
  logic [2:0]  m0_rresp   [2];
  logic        m0_rready  [2];
  logic        m1_arvalid [2];
  logic [63:0] m1_araddr  [2];
  logic [2:0]  m1_arprot  [2];
  logic        m1_arready [2];
  logic        m1_rvalid  [2];
  logic [63:0] m1_rdata   [2];
  logic [2:0]  m1_rresp   [2];
  logic        m1_rready  [2];
  logic        s_arvalid  [2];
  logic [63:0] s_araddr   [2];
  logic [2:0]  s_arprot   [2];
  logic        s_arready  [2];
  logic        s_rvalid   [2];
  logic [63:0] s_rdata    [2];
  logic [2:0]  s_rresp    [2];
  logic        s_rready   [2];
  arb_state_e  dbg_state  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_lite_read_arbiter #(
      .ADDR_W (64),
      .DATA_W (64),
      .ARB_MODE (g)
    ) u_dut (
      .ACLK       (aclk),
      .ARESETn    (aresetn[g]),
      .M0_ARVALID (m0_arvalid[g]),
      .M0_ARADDR  (m0_araddr[g]),
      .M0_ARPROT  (m0_arprot[g]),
      .M0_ARREADY (m0_arready[g]),
      .M0_RVALID  (m0_rvalid[g]),
      .M0_RDATA   (m0_rdata[g]),
      .M0_RRESP   (m0_rresp[g]),
      .M0_RREADY  (m0_rready[g]),
      .M1_ARVALID (m1_arvalid[g]),
      .M1_ARADDR  (m1_araddr[g]),
      .M1_ARPROT  (m1_arprot[g]),
      .M1_ARREADY (m1_arready[g]),
      .M1_RVALID  (m1_rvalid[g]),
      .M1_RDATA   (m1_rdata[g]),
      .M1_RRESP   (m1_rresp[g]),
      .M1_RREADY  (m1_rready[g]),
      .S_ARVALID  (s_arvalid[g]),
      .S_ARADDR   (s_araddr[g]),
      .S_ARPROT   (s_arprot[g]),
      .S_ARREADY  (s_arready[g]),
      .S_RVALID   (s_rvalid[g]),
      .S_RDATA    (s_rdata[g]),
      .S_RRESP    (s_rresp[g]),
      .S_RREADY   (s_rready[g]),
      .dbg_state  (dbg_state[g])
    );
  end

  // ---------------- reactive slave ----------------
  int ar_cnt [2];
  int r_cnt  [2];

  always @(posedge aclk) begin : slave_model
    logic        arh [2];
    logic        rh  [2];
    logic [63:0] a   [2];
    for (int g = 0; g < 2; g++) begin
      arh[g] = s_arvalid[g] & s_arready[g];
      rh[g]  = s_rvalid[g] & s_rready[g];
      a[g]   = s_araddr[g];
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      if (!aresetn[g]) begin
        s_rvalid[g] = 1'b0;
        s_rdata[g]  = '0;
        s_rresp[g]  = '0;
      end else begin
        if (rh[g] === 1'b1) begin
          s_rvalid[g] = 1'b0;
          r_cnt[g]++;
        end
        if (arh[g] === 1'b1) begin
          s_rvalid[g] = 1'b1;
          s_rdata[g]  = a[g] - 64'h7FFF_FFED;
          s_rresp[g]  = a[g][4] ? RESP_SLVERR : RESP_OKAY;
          ar_cnt[g]++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int d);
    aresetn[d]    = 1'b0;
    m0_arvalid[d] = 1'b0; m0_araddr[d] = '0; m0_arprot[d] = '0; m0_rready[d] = 1'b1;
    m1_arvalid[d] = 1'b0; m1_araddr[d] = '0; m1_arprot[d] = '0; m1_rready[d] = 1'b1;
    s_arready[d]  = 1'b1;
    repeat (2) tick();
    aresetn[d] = 1'b1;
    tick();
  endtask

  // Entered at the start of an IDLE cycle with the winner requesting.
  // Walks IDLE -> ADDR -> DATA -> IDLE with the slave ready and the winner's RREADY high.
  task automatic serve(input int d, input bit w1, input logic [63:0] addr,
                       input logic [63:0] data, input logic [2:0] resp,
                       input bit keep, input logic [63:0] next_addr, input string tag);
    @(negedge aclk);
    check({tag, " win arready"},  w1 ? m1_arready[d] : m0_arready[d], 1);
    check({tag, " lose arready"}, w1 ? m0_arready[d] : m1_arready[d], 0);
    tick();
    if (w1) begin m1_arvalid[d] = keep; m1_araddr[d] = next_addr; end
    else    begin m0_arvalid[d] = keep; m0_araddr[d] = next_addr; end
    @(negedge aclk);
    check({tag, " s_arvalid"}, s_arvalid[d], 1);
    check({tag, " s_araddr"},  s_araddr[d], addr);
    check({tag, " lose arready addr"}, w1 ? m0_arready[d] : m1_arready[d], 0);
    tick();
    @(negedge aclk);
    check({tag, " win rvalid"},  w1 ? m1_rvalid[d] : m0_rvalid[d], 1);
    check({tag, " win rdata"},   w1 ? m1_rdata[d]  : m0_rdata[d], data);
    check({tag, " win rresp"},   w1 ? m1_rresp[d]  : m0_rresp[d], {61'd0, resp});
    check({tag, " lose rvalid"}, w1 ? m0_rvalid[d] : m1_rvalid[d], 0);
    check({tag, " lose rdata"},  w1 ? m0_rdata[d]  : m1_rdata[d], 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c_ar, c_r;
    for (int d = 0; d < 2; d++) begin
      aresetn[d]    = 1'b0;
      m0_arvalid[d] = 1'b0; m0_araddr[d] = '0; m0_arprot[d] = '0; m0_rready[d] = 1'b1;
      m1_arvalid[d] = 1'b0; m1_araddr[d] = '0; m1_arprot[d] = '0; m1_rready[d] = 1'b1;
      s_arready[d]  = 1'b1;
    end
    @(negedge aclk);
    check("rst s_arvalid",  s_arvalid[0], 0);
    check("rst s_araddr",   s_araddr[0], 0);
    check("rst s_rready",   s_rready[0], 0);
    check("rst m0_arready", m0_arready[0], 0);
    check("rst m1_rvalid",  m1_rvalid[0], 0);
    check("rst state",      dbg_state[0], ARB_IDLE);
    do_reset(0);
    do_reset(1);

    // ---- 1: single M0 read ----
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 64'h8000_0000; m0_arprot[0] = 3'b010;
    @(negedge aclk);
    check("t1 m0_arready",   m0_arready[0], 1);
    check("t1 m1_arready",   m1_arready[0], 0);
    check("t1 s_arvalid idle", s_arvalid[0], 0);
    tick();
    m0_arvalid[0] = 1'b0;
    @(negedge aclk);
    check("t1 s_arvalid", s_arvalid[0], 1);
    check("t1 s_araddr",  s_araddr[0], 64'h8000_0000);
    check("t1 s_arprot",  s_arprot[0], 3'b010);
    check("t1 state addr", dbg_state[0], ARB_ADDR);
    tick();
    @(negedge aclk);
    check("t1 m0_rvalid", m0_rvalid[0], 1);
    check("t1 m0_rdata",  m0_rdata[0], 64'h13);
    check("t1 m0_rresp",  m0_rresp[0], 0);
    check("t1 m1_rvalid", m1_rvalid[0], 0);
    check("t1 s_rready",  s_rready[0], 1);
    tick();
    @(negedge aclk);
    check("t1 m0_rvalid after", m0_rvalid[0], 0);
    check("t1 state idle",      dbg_state[0], ARB_IDLE);
    tick();

    // ---- 2: round-robin, both requesting from reset ----
    do_reset(0);
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 64'h8000_0000;
    m1_arvalid[0] = 1'b1; m1_araddr[0] = 64'h8000_0110;
    serve(0, 0, 64'h8000_0000, 64'h13,  3'b000, 1, 64'h8000_0020, "t2 g0");
    serve(0, 1, 64'h8000_0110, 64'h123, 3'b010, 1, 64'h8000_0130, "t2 g1");
    serve(0, 0, 64'h8000_0020, 64'h33,  3'b000, 0, 64'h0,         "t2 g2");
    serve(0, 1, 64'h8000_0130, 64'h143, 3'b010, 0, 64'h0,         "t2 g3");

    // ---- 3: fixed priority ----
    m0_arvalid[1] = 1'b1; m0_araddr[1] = 64'h8000_0000;
    m1_arvalid[1] = 1'b1; m1_araddr[1] = 64'h8000_0110;
    serve(1, 0, 64'h8000_0000, 64'h13,  3'b000, 1, 64'h8000_0020, "t3 g0");
    serve(1, 0, 64'h8000_0020, 64'h33,  3'b000, 1, 64'h8000_0040, "t3 g1");
    serve(1, 0, 64'h8000_0040, 64'h53,  3'b000, 0, 64'h0,         "t3 g2");
    serve(1, 1, 64'h8000_0110, 64'h123, 3'b010, 0, 64'h0,         "t3 g3");

    // ---- 4: slave AR stall then master R stall ----
    do_reset(0);
    c_ar = ar_cnt[0]; c_r = r_cnt[0];
    s_arready[0] = 1'b0; m0_rready[0] = 1'b0;
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 64'h8000_0040; m0_arprot[0] = 3'b101;
    @(negedge aclk);
    check("t4 m0_arready", m0_arready[0], 1);
    tick();
    m0_arvalid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t4 stall s_arvalid", s_arvalid[0], 1);
      check("t4 stall s_araddr",  s_araddr[0], 64'h8000_0040);
      check("t4 stall s_arprot",  s_arprot[0], 3'b101);
      tick();
    end
    s_arready[0] = 1'b1;
    @(negedge aclk);
    check("t4 s_arvalid hs", s_arvalid[0], 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("t4 stall m0_rvalid", m0_rvalid[0], 1);
      check("t4 stall m0_rdata",  m0_rdata[0], 64'h53);
      check("t4 stall s_rready",  s_rready[0], 0);
      check("t4 stall state",     dbg_state[0], ARB_DATA);
      tick();
    end
    m0_rready[0] = 1'b1;
    @(negedge aclk);
    check("t4 m0_rvalid hs", m0_rvalid[0], 1);
    check("t4 s_rready hs",  s_rready[0], 1);
    repeat (3) tick();
    @(negedge aclk);
    check("t4 state idle", dbg_state[0], ARB_IDLE);
    check("t4 ar count",   ar_cnt[0] - c_ar, 1);
    check("t4 r count",    r_cnt[0] - c_r, 1);
    tick();

    // ---- 5: M1 request during M0 DATA ----
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 64'h8000_0060;
    @(negedge aclk);
    check("t5 m0_arready", m0_arready[0], 1);
    tick();
    m0_arvalid[0] = 1'b0;
    @(negedge aclk);
    check("t5 state addr", dbg_state[0], ARB_ADDR);
    tick();
    m1_arvalid[0] = 1'b1; m1_araddr[0] = 64'h8000_0010; m1_arprot[0] = 3'b000;
    m0_rready[0]  = 1'b0;
    @(negedge aclk);
    check("t5 m1_arready data0", m1_arready[0], 0);
    check("t5 m0_rvalid",        m0_rvalid[0], 1);
    check("t5 m0_rdata",         m0_rdata[0], 64'h73);
    tick();
    m0_rready[0] = 1'b1;
    @(negedge aclk);
    check("t5 m1_arready data1", m1_arready[0], 0);
    check("t5 s_rready",         s_rready[0], 1);
    tick();
    serve(0, 1, 64'h8000_0010, 64'h23, 3'b010, 0, 64'h0, "t5 m1");

    // ---- 6: reset pulse during ADDR ----
    c_ar = ar_cnt[0];
    s_arready[0]  = 1'b0;
    m0_arvalid[0] = 1'b1; m0_araddr[0] = 64'h8000_0000; m0_arprot[0] = 3'b001;
    @(negedge aclk);
    check("t6 m0_arready", m0_arready[0], 1);
    tick();
    m0_arvalid[0] = 1'b0;
    m1_arvalid[0] = 1'b1; m1_araddr[0] = 64'h8000_0010; m1_arprot[0] = 3'b100;
    @(negedge aclk);
    check("t6 s_arvalid pre", s_arvalid[0], 1);
    check("t6 state pre",     dbg_state[0], ARB_ADDR);
    #1;
    aresetn[0] = 1'b0;
    #1;
    check("t6 rst s_arvalid",  s_arvalid[0], 0);
    check("t6 rst s_araddr",   s_araddr[0], 0);
    check("t6 rst s_arprot",   s_arprot[0], 0);
    check("t6 rst m0_arready", m0_arready[0], 0);
    check("t6 rst m1_arready", m1_arready[0], 0);
    check("t6 rst s_rready",   s_rready[0], 0);
    check("t6 rst m0_rvalid",  m0_rvalid[0], 0);
    check("t6 rst m1_rdata",   m1_rdata[0], 0);
    check("t6 rst state",      dbg_state[0], ARB_IDLE);
    repeat (2) tick();
    aresetn[0]   = 1'b1;
    s_arready[0] = 1'b1;
    serve(0, 1, 64'h8000_0010, 64'h23, 3'b010, 0, 64'h0, "t6 m1");
    @(negedge aclk);
    check("t6 ar count", ar_cnt[0] - c_ar, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
